// File: rtl/mem_arbiter_if.sv
// Requester, RAM and status bundle between the mem_arbiter and its neighbours.
// Latency: none, this file only groups wires.
// Backpressure: each requester holds its request until its ready pulse.
//
// Ports of the bundle:
//   IF  : if_req, if_addr -> if_rdata, if_ready
//   MEM : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb -> mem_rdata, mem_ready
//   LD  : ld_req, ld_addr, ld_wdata -> ld_ready
//   RAM : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
//   status: gnt_id (0 none, 1 IF, 2 MEM, 3 LD), busy
// The slave modport is the arbiter's view.
// The master modport is the view of the requesters plus the RAM wrapper.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 14
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ready;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [1:0]        gnt_id;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready,
        input  ld_req, ld_addr, ld_wdata,
        output ld_ready,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output gnt_id, busy
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready,
        output ld_req, ld_addr, ld_wdata,
        input  ld_ready,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  gnt_id, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported I/D RAM between the loader (LD), MEM stage and IF.
// Latency from request sampled in IDLE: write ready at +2, read ready at +2+MEM_LAT.
// Backpressure: losers see ready low and stall; one access in flight, one ready pulse each.
//
// Ports: cpuclk, rst (synchronous, active high), bus (mem_arbiter_if.slave).
// bus carries the IF, MEM and LD req/ready handshakes and the RAM port.
// It also carries gnt_id (0 none, 1 IF, 2 MEM, 3 LD) and busy (FSM not in IDLE).
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RAM_AW     = 14,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          cpuclk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_MEM  = 2'd2;
    localparam logic [1:0] GNT_LD   = 2'd3;

    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int WAIT_W = 2;

    state_t            state;
    logic [1:0]        gnt_q;
    logic              we_q;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              ram_en_q;
    logic [3:0]        ram_we_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic              ld_ready_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;
    logic              busy_q;

    // Winner of the current IDLE sample.
    logic [1:0]        win_id;
    logic              win_we;
    logic [RAM_AW-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [3:0]        win_wstrb;
    logic              if_starved;

    assign if_starved = bus.if_req && (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        win_id    = GNT_NONE;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_wstrb = 4'h0;
        if (bus.ld_req) begin
            win_id    = GNT_LD;
            win_we    = 1'b1;
            win_addr  = bus.ld_addr[RAM_AW+1:2];
            win_wdata = bus.ld_wdata;
            win_wstrb = 4'hF;
        end else if (if_starved) begin
            // IF has lost STARVE_MAX times in a row to MEM: let it through once.
            win_id    = GNT_IF;
            win_addr  = bus.if_addr[RAM_AW+1:2];
        end else if (bus.mem_req) begin
            win_id    = GNT_MEM;
            win_we    = bus.mem_we;
            win_addr  = bus.mem_addr[RAM_AW+1:2];
            win_wdata = bus.mem_wdata;
            win_wstrb = bus.mem_wstrb;
        end else if (bus.if_req) begin
            win_id    = GNT_IF;
            win_addr  = bus.if_addr[RAM_AW+1:2];
        end
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state       <= IDLE;
            gnt_q       <= GNT_NONE;
            we_q        <= 1'b0;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'h0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_id != GNT_NONE) begin
                        gnt_q    <= win_id;
                        we_q     <= win_we;
                        addr_q   <= win_addr;
                        wdata_q  <= win_wdata;
                        ram_en_q <= 1'b1;
                        ram_we_q <= win_we ? win_wstrb : 4'h0;
                        busy_q   <= 1'b1;
                        state    <= ISSUE;
                        if (win_id == GNT_IF) begin
                            starve_cnt <= '0;
                        end else if (win_id == GNT_MEM && bus.if_req &&
                                     starve_cnt != CNT_W'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 4'h0;
                    if (we_q) begin
                        // Writes need no data phase: acknowledge next cycle.
                        mem_ready_q <= (gnt_q == GNT_MEM);
                        ld_ready_q  <= (gnt_q == GNT_LD);
                        state       <= RESP;
                    end else begin
                        wait_cnt <= WAIT_W'(MEM_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (gnt_q == GNT_IF) begin
                            if_rdata_q <= bus.ram_rdata;
                        end
                        if (gnt_q == GNT_MEM) begin
                            mem_rdata_q <= bus.ram_rdata;
                        end
                        if_ready_q  <= (gnt_q == GNT_IF);
                        mem_ready_q <= (gnt_q == GNT_MEM);
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                RESP: begin
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                    ld_ready_q  <= 1'b0;
                    gnt_q       <= GNT_NONE;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The enable is gated with rst so a reset landing in ISSUE cannot touch the RAM.
    assign bus.ram_en    = ram_en_q & ~rst;
    assign bus.ram_we    = ram_we_q & {4{~rst}};
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.busy      = busy_q;

    // Byte offset and bits above the RAM window are not needed for word addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[ADDR_W-1:RAM_AW+2],  bus.if_addr[1:0],
                                bus.mem_addr[ADDR_W-1:RAM_AW+2], bus.mem_addr[1:0],
                                bus.ld_addr[ADDR_W-1:RAM_AW+2],  bus.ld_addr[1:0]};
endmodule
